// File: rtl/lift_call_panel.sv
// lift_call_panel: debounced floor-call latch with SCAN target selection and a valid/ack offer port.
// Define LIFT_PANEL_DEBOUNCE_EN to build the per-floor debounce counters; otherwise a press is the synchronized rising edge.
module lift_call_panel #(
    parameter int NUM_FLOORS = 4,
    parameter int FLOOR_W    = 2,
    parameter int DEB_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  res,
    input  logic [NUM_FLOORS-1:0] btn,
    input  logic [FLOOR_W-1:0]    cur_floor,
    input  logic                  req_ack,
    output logic                  req_valid,
    output logic [FLOOR_W-1:0]    req_floor,
    output logic [NUM_FLOORS-1:0] pending,
    output logic                  dir_up
);
    typedef enum logic [1:0] {IDLE, SELECT, OFFER} state_t;
    state_t state, state_nx;
    logic [NUM_FLOORS-1:0] sync1, sync2, lvl, lvl_q, press, clr;
    logic [FLOOR_W-1:0] up_f, dn_f, tgt;
    logic up_hit, dn_hit, here, dir_nx;

    always_ff @(posedge clk or negedge res)
        if (!res) begin
            sync1 <= '0;
            sync2 <= '0;
            lvl_q <= '0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            lvl_q <= lvl;
        end

`ifdef LIFT_PANEL_DEBOUNCE_EN
    localparam int CW = $clog2(DEB_CYCLES);
    localparam logic [CW-1:0] TOP = CW'(DEB_CYCLES - 1);
    logic [CW-1:0] cnt [NUM_FLOORS];

    // level rises only after the counter has saturated with the input still high
    always_ff @(posedge clk or negedge res)
        if (!res) begin
            for (int i = 0; i < NUM_FLOORS; i++) cnt[i] <= '0;
            lvl <= '0;
        end else
            for (int i = 0; i < NUM_FLOORS; i++) begin
                cnt[i] <= !sync2[i] ? '0 : (cnt[i] == TOP ? TOP : cnt[i] + 1'b1);
                lvl[i] <= sync2[i] && (lvl[i] || cnt[i] == TOP);
            end
`else
    assign lvl = sync2;
`endif

    assign press = lvl & ~lvl_q;

    always_comb begin
        up_hit = 1'b0;
        up_f   = '0;
        dn_hit = 1'b0;
        dn_f   = '0;
        for (int i = NUM_FLOORS - 1; i >= 0; i--)
            if (pending[i] && i > int'(cur_floor)) begin
                up_hit = 1'b1;
                up_f   = FLOOR_W'(i);
            end
        for (int i = 0; i < NUM_FLOORS; i++)
            if (pending[i] && i < int'(cur_floor)) begin
                dn_hit = 1'b1;
                dn_f   = FLOOR_W'(i);
            end
    end

    assign here   = int'(cur_floor) < NUM_FLOORS && pending[cur_floor];
    assign tgt    = here ? cur_floor : dir_up ? (up_hit ? up_f : dn_f) : (dn_hit ? dn_f : up_f);
    assign dir_nx = here ? dir_up : dir_up ? up_hit : !dn_hit;

    always_comb begin
        state_nx = state;
        clr      = '0;
        if (state == IDLE && |pending) state_nx = SELECT;
        if (state == SELECT) state_nx = OFFER;
        if (state == OFFER && req_ack) begin
            state_nx       = IDLE;
            clr[req_floor] = 1'b1;
        end
    end

    // a press in the same cycle as the ack clear wins
    always_ff @(posedge clk or negedge res)
        if (!res) begin
            state     <= IDLE;
            pending   <= '0;
            req_floor <= '0;
            dir_up    <= 1'b1;
        end else begin
            state   <= state_nx;
            pending <= (pending & ~clr) | press;
            if (state == SELECT) begin
                req_floor <= tgt;
                dir_up    <= dir_nx;
            end
        end

    assign req_valid = state == OFFER;
endmodule

// File: tb/tb_lift_call_panel.sv
// tb_lift_call_panel: randomized scoreboard bench; a set-based SCAN model predicts each offer and a monitor checks it.
module tb_lift_call_panel;
    localparam int NF = 4, FW = 2, DEB = 16;
`ifdef LIFT_PANEL_DEBOUNCE_EN
    localparam int LAT = DEB + 3;
`else
    localparam int LAT = 3;
`endif
    typedef struct {int floor; bit dir;} exp_t;

    logic clk = 0, res = 0, req_ack = 0, req_valid, dir_up;
    logic [NF-1:0] btn = '0, pending;
    logic [FW-1:0] cur_floor = '0, req_floor;
    int n_cmp = 0, n_bad = 0;
    exp_t exp_q[$];
    exp_t e;
    bit model_dir = 1;
    logic [NF-1:0] mask = '0;
    int tgt_m = 0;
    bit prev_v = 0;
    int held = 0;

    always #5 clk = ~clk;

    lift_call_panel #(.NUM_FLOORS(NF), .FLOOR_W(FW), .DEB_CYCLES(DEB)) dut (
        .clk(clk), .res(res), .btn(btn), .cur_floor(cur_floor), .req_ack(req_ack),
        .req_valid(req_valid), .req_floor(req_floor), .pending(pending), .dir_up(dir_up)
    );

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // SCAN rule on a set of calls: serve here, else keep heading, else turn around
    function automatic int scan(input logic [NF-1:0] m, input int cur);
        int above = -1, below = -1;
        if (cur < NF && m[cur]) return cur;
        for (int f = cur + 1; f < NF && above < 0; f++) if (m[f]) above = f;
        for (int f = cur - 1; f >= 0 && below < 0; f--) if (f < NF && m[f]) below = f;
        if (model_dir) begin
            if (above >= 0) return above;
            model_dir = 0;
            return below;
        end
        if (below >= 0) return below;
        model_dir = 1;
        return above;
    endfunction

    task automatic predict(input int cur);
        exp_t x;
        x.floor = scan(mask, cur);
        x.dir   = model_dir;
        tgt_m   = x.floor;
        exp_q.push_back(x);
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!req_valid && n < 200) begin
            tick();
            n++;
        end
        check(name, int'(req_valid), 1);
    endtask

    task automatic do_ack(input int dly, input int new_cur, input bit keep);
        tick(dly);
        cur_floor = FW'(new_cur);
        req_ack   = 1;
        tick();
        req_ack     = 0;
        mask[tgt_m] = keep;
        check("pending_after_ack", int'(pending), int'(mask));
        check("valid_after_ack", int'(req_valid), 0);
        if (mask != 0) predict(new_cur);
    endtask

    always @(negedge clk) begin
        if (!res) prev_v = 0;
        else begin
            if (req_valid && !prev_v) begin
                check("offer_expected", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("req_floor", int'(req_floor), e.floor);
                    check("dir_up", int'(dir_up), int'(e.dir));
                end
                held = int'(req_floor);
            end else if (req_valid)
                check("floor_stable", int'(req_floor), held);
            prev_v = req_valid;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int n;
        tick(3);
        check("rst_valid", int'(req_valid), 0);
        check("rst_floor", int'(req_floor), 0);
        check("rst_pending", int'(pending), 0);
        check("rst_dir", int'(dir_up), 1);
        res = 1;
        tick(2);

        cur_floor = 0;
        btn  = 4'b0100;
        mask = 4'b0100;
        predict(0);
        n = 0;
        do begin tick(); n++; end while (!pending[2] && n < 100);
        check("press_latency", n, LAT);
        check("lamps_first", int'(pending), 4);
        n = 0;
        do begin tick(); n++; end while (!req_valid && n < 10);
        check("offer_latency", n, 2);
        btn = '0;
        tick(5);
        do_ack(0, 0, 0);
        tick(LAT + 4);

`ifdef LIFT_PANEL_DEBOUNCE_EN
        btn[1] = 1;
        tick(DEB - 2);
        btn = '0;
        tick(LAT + 10);
        check("glitch_pending", int'(pending), 0);
        check("glitch_valid", int'(req_valid), 0);
`endif

        cur_floor = 2;
        btn  = 4'b1001;
        mask = 4'b1001;
        predict(2);
        wait_valid("scan_offer1");
        check("scan_lamps", int'(pending), 9);
        btn = '0;
        do_ack(2, 3, 0);
        wait_valid("scan_offer2");
        do_ack(1, 0, 0);
        tick(LAT + 4);

        cur_floor = 0;
        btn  = 4'b0010;
        mask = 4'b0010;
        predict(0);
        wait_valid("setwin_offer1");
        btn = '0;
        tick(LAT + 3);
        btn[1] = 1;
        do_ack(LAT - 1, 0, 1);
        wait_valid("setwin_offer2");
        do_ack(0, 1, 0);
        btn = '0;
        tick(LAT + 4);

        for (int r = 0; r < 30; r++) begin
            int cur;
            cur = int'($urandom_range(0, NF - 1));
            cur_floor = FW'(cur);
            mask = NF'($urandom_range(1, (1 << NF) - 1));
            btn  = mask;
            req_ack = 1'($urandom_range(0, 1));
            predict(cur);
            tick();
            req_ack = 0;
            while (mask != 0) begin
                wait_valid("rand_offer");
                check("rand_lamps", int'(pending), int'(mask));
                do_ack(int'($urandom_range(0, 5)), int'($urandom_range(0, NF - 1)), 0);
            end
            btn = '0;
            tick(LAT + 4);
            check("rand_idle", int'(req_valid), 0);
        end

        cur_floor = 0;
        btn  = 4'b0110;
        mask = 4'b0110;
        predict(0);
        wait_valid("rst_offer");
        btn = '0;
        res = 0;
        #1;
        check("midrst_valid", int'(req_valid), 0);
        check("midrst_pending", int'(pending), 0);
        check("midrst_floor", int'(req_floor), 0);
        check("midrst_dir", int'(dir_up), 1);
        exp_q.delete();
        model_dir = 1;
        mask = '0;
        tick(2);
        res = 1;
        n = 0;
        repeat (30) begin
            tick();
            if (req_valid) n++;
        end
        check("post_rst_quiet", n, 0);

        check("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
